// File: rtl/btb_pkg.sv
// btb_pkg: shared types, counter encodings and the 2-bit saturating counter rule for the BTB
package btb_pkg;

    localparam int BTB_WIDTH = 32;
    localparam int BTB_TAG_W = 8;

    typedef logic [1:0] btb_ctr_t;

    localparam btb_ctr_t CTR_SNT = 2'b00;
    localparam btb_ctr_t CTR_WNT = 2'b01;
    localparam btb_ctr_t CTR_WT  = 2'b10;
    localparam btb_ctr_t CTR_ST  = 2'b11;

    typedef struct packed {
        logic                 valid;
        logic [BTB_TAG_W-1:0] tag;
        logic [BTB_WIDTH-1:0] target;
        btb_ctr_t             ctr;
    } btb_entry_t;

    function automatic btb_ctr_t ctr_next(btb_ctr_t ctr, logic taken, logic jump);
        return jump  ? CTR_ST :
               taken ? ((ctr == CTR_ST)  ? ctr : ctr + 2'd1) :
                       ((ctr == CTR_SNT) ? ctr : ctr - 2'd1);
    endfunction

endpackage

// File: rtl/btb_sat_ctr.sv
// btb_sat_ctr: combinational next state of a 2-bit direction counter
//   ctr_i   current counter
//   taken_i resolved outcome
//   jump_i  unconditional jump, forces strong-taken
//   ctr_o   next counter
module btb_sat_ctr
    import btb_pkg::*;
(
    input  btb_ctr_t ctr_i,
    input  logic     taken_i,
    input  logic     jump_i,
    output btb_ctr_t ctr_o
);

    assign ctr_o = ctr_next(ctr_i, taken_i, jump_i);

endmodule

// File: rtl/btb_predictor.sv
// btb_predictor: direct-mapped BTB with 2-bit direction counters; optional perf counters via BTB_PERF_CNT_EN
//   clk_i, rst_ni                      clock, async active-low reset
//   lookup_pc_i -> pred_hit_o/pred_taken_o/pred_target_o   combinational IF lookup
//   upd_en_i/upd_pc_i/upd_taken_i/upd_jump_i/upd_target_i  EX resolution update
//   mispred_o                          registered mispredict flag for the last update
//   perf_lookup_o/perf_hit_o/perf_mispred_o   saturating event counters (BTB_PERF_CNT_EN only)
module btb_predictor
    import btb_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int TAG_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] lookup_pc_i,
    output logic             pred_hit_o,
    output logic             pred_taken_o,
    output logic [WIDTH-1:0] pred_target_o,
    input  logic             upd_en_i,
    input  logic [WIDTH-1:0] upd_pc_i,
    input  logic             upd_taken_i,
    input  logic             upd_jump_i,
    input  logic [WIDTH-1:0] upd_target_i,
`ifdef BTB_PERF_CNT_EN
    output logic [WIDTH-1:0] perf_lookup_o,
    output logic [WIDTH-1:0] perf_hit_o,
    output logic [WIDTH-1:0] perf_mispred_o,
`endif
    output logic             mispred_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int TAG_LO = IDX_W + 2;
    localparam int TAG_HI = IDX_W + 2 + TAG_W - 1;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [WIDTH-1:0] target;
        btb_ctr_t         ctr;
    } entry_t;

    entry_t mem [DEPTH];

    logic [IDX_W-1:0] l_idx, u_idx;
    logic [TAG_W-1:0] l_tag, u_tag;
    entry_t           l_e, u_e;
    logic             u_hit, p_taken;
    logic [WIDTH-1:0] p_target;
    btb_ctr_t         ctr_nx;
    logic             unused_pc_bits;

    assign l_idx = lookup_pc_i[IDX_W+1:2];
    assign l_tag = lookup_pc_i[TAG_HI:TAG_LO];
    assign u_idx = upd_pc_i[IDX_W+1:2];
    assign u_tag = upd_pc_i[TAG_HI:TAG_LO];
    assign unused_pc_bits = ^{lookup_pc_i[1:0], lookup_pc_i[WIDTH-1:TAG_HI+1],
                              upd_pc_i[1:0], upd_pc_i[WIDTH-1:TAG_HI+1]};

    assign l_e           = mem[l_idx];
    assign pred_hit_o    = l_e.valid && (l_e.tag == l_tag);
    assign pred_taken_o  = pred_hit_o & l_e.ctr[1];
    assign pred_target_o = pred_hit_o ? l_e.target : '0;

    // Pre-update prediction for the resolving PC; a miss predicts not-taken to target 0.
    assign u_e      = mem[u_idx];
    assign u_hit    = u_e.valid && (u_e.tag == u_tag);
    assign p_taken  = u_hit & u_e.ctr[1];
    assign p_target = u_hit ? u_e.target : '0;

    btb_sat_ctr u_sat_ctr (
        .ctr_i   (u_e.ctr),
        .taken_i (upd_taken_i),
        .jump_i  (upd_jump_i),
        .ctr_o   (ctr_nx)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};
            mispred_o <= 1'b0;
        end else begin
            mispred_o <= upd_en_i & ((p_taken != upd_taken_i) | (upd_taken_i & (p_target != upd_target_i)));
            if (upd_en_i && u_hit) begin
                mem[u_idx].ctr <= ctr_nx;
                if (upd_taken_i) mem[u_idx].target <= upd_target_i;
            end else if (upd_en_i && upd_taken_i) begin
                mem[u_idx] <= '{valid: 1'b1, tag: u_tag, target: upd_target_i, ctr: upd_jump_i ? CTR_ST : CTR_WT};
            end
        end
    end

`ifdef BTB_PERF_CNT_EN
    function automatic logic [WIDTH-1:0] sat_inc(logic [WIDTH-1:0] x);
        return x + WIDTH'(!(&x));
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_lookup_o  <= '0;
            perf_hit_o     <= '0;
            perf_mispred_o <= '0;
        end else begin
            perf_lookup_o  <= sat_inc(perf_lookup_o);
            perf_hit_o     <= pred_hit_o ? sat_inc(perf_hit_o) : perf_hit_o;
            perf_mispred_o <= mispred_o ? sat_inc(perf_mispred_o) : perf_mispred_o;
        end
    end
`endif

endmodule

// File: tb/tb_btb_predictor.sv
// tb_btb_predictor: directed vector table plus randomized run against a behavioural BTB model
module tb_btb_predictor;

    localparam int W = 32;
    localparam int D = 16;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic [W-1:0] lookup_pc_i, upd_pc_i, upd_target_i, pred_target_o;
    logic         pred_hit_o, pred_taken_o, upd_en_i, upd_taken_i, upd_jump_i, mispred_o;
`ifdef BTB_PERF_CNT_EN
    logic [W-1:0] perf_lookup_o, perf_hit_o, perf_mispred_o;
`endif

    int n_checks = 0;
    int n_fail = 0;

    btb_predictor dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .lookup_pc_i   (lookup_pc_i),
        .pred_hit_o    (pred_hit_o),
        .pred_taken_o  (pred_taken_o),
        .pred_target_o (pred_target_o),
        .upd_en_i      (upd_en_i),
        .upd_pc_i      (upd_pc_i),
        .upd_taken_i   (upd_taken_i),
        .upd_jump_i    (upd_jump_i),
        .upd_target_i  (upd_target_i),
`ifdef BTB_PERF_CNT_EN
        .perf_lookup_o (perf_lookup_o),
        .perf_hit_o    (perf_hit_o),
        .perf_mispred_o(perf_mispred_o),
`endif
        .mispred_o     (mispred_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic         en;
        logic [W-1:0] pc;
        logic         tk;
        logic         jp;
        logic [W-1:0] tgt;
        logic [W-1:0] lpc;
        logic         e_hit;
        logic         e_tk;
        logic [W-1:0] e_tgt;
        logic         e_mis;
    } vec_t;

    // Behavioural model: per-slot valid/tag/target and an integer counter 0..3.
    bit          m_valid [D];
    int unsigned m_tag   [D];
    int unsigned m_tgt   [D];
    int          m_ctr   [D];

    function automatic int slot(input logic [W-1:0] pc);
        return int'((pc / 4) % D);
    endfunction

    function automatic int unsigned tagof(input logic [W-1:0] pc);
        return (pc / (4 * D)) % 256;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < D; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
        end
    endfunction

    task automatic model_predict(input logic [W-1:0] pc, output logic hit, output logic tk, output logic [W-1:0] tgt);
        int s = slot(pc);
        hit = m_valid[s] && m_tag[s] == tagof(pc);
        tk  = hit && m_ctr[s] >= 2;
        tgt = hit ? m_tgt[s] : 0;
    endtask

    // Applies one update to the model and returns the expected mispredict flag.
    task automatic model_update(input logic [W-1:0] pc, input logic tk, input logic jp, input logic [W-1:0] tgt, output logic mis);
        logic h, ptk;
        logic [W-1:0] ptgt;
        int s = slot(pc);
        model_predict(pc, h, ptk, ptgt);
        mis = (ptk != tk) || (tk && ptgt != tgt);
        if (h) begin
            m_ctr[s] = jp ? 3 : tk ? (m_ctr[s] < 3 ? m_ctr[s] + 1 : 3) : (m_ctr[s] > 0 ? m_ctr[s] - 1 : 0);
            if (tk) m_tgt[s] = tgt;
        end else if (tk) begin
            m_valid[s] = 1; m_tag[s] = tagof(pc); m_tgt[s] = tgt; m_ctr[s] = jp ? 3 : 2;
        end
    endtask

    task automatic lookup_check(input string nm, input logic [W-1:0] pc, input logic h, input logic t, input logic [W-1:0] g);
        lookup_pc_i = pc;
        #1;
        check({nm, " hit"}, W'(pred_hit_o), W'(h));
        check({nm, " taken"}, W'(pred_taken_o), W'(t));
        check({nm, " target"}, pred_target_o, g);
    endtask

    vec_t vecs [$];

    initial begin
        logic eh, et, em;
        logic [W-1:0] eg;
        rst_ni = 1'b0; upd_en_i = 0; upd_pc_i = 0; upd_taken_i = 0; upd_jump_i = 0; upd_target_i = 0;
        lookup_pc_i = 0;
        repeat (2) @(posedge clk_i);
        #1;
`ifdef BTB_PERF_CNT_EN
        check("perf_lookup reset", perf_lookup_o, 0);
        check("perf_hit reset", perf_hit_o, 0);
        check("perf_mispred reset", perf_mispred_o, 0);
`endif
        rst_ni = 1'b1;

        //            en  pc      tk jp tgt     lpc     hit tk tgt     mis
        vecs.push_back('{0, 'h000, 0, 0, 'h000, 'h100, 0, 0, 'h000, 0});
        vecs.push_back('{1, 'h100, 1, 0, 'h200, 'h100, 0, 0, 'h000, 1});
        vecs.push_back('{0, 'h000, 0, 0, 'h000, 'h100, 1, 1, 'h200, 0});
        vecs.push_back('{1, 'h100, 0, 0, 'h000, 'h100, 1, 1, 'h200, 1});
        vecs.push_back('{1, 'h100, 0, 0, 'h000, 'h100, 1, 0, 'h200, 0});
        vecs.push_back('{1, 'h100, 0, 0, 'h000, 'h100, 1, 0, 'h200, 0});
        vecs.push_back('{1, 'h100, 1, 0, 'h200, 'h100, 1, 0, 'h200, 1});
        vecs.push_back('{1, 'h100, 1, 0, 'h200, 'h100, 1, 0, 'h200, 1});
        vecs.push_back('{1, 'h100, 1, 0, 'h200, 'h100, 1, 1, 'h200, 0});
        vecs.push_back('{1, 'h100, 1, 0, 'h200, 'h100, 1, 1, 'h200, 0});
        vecs.push_back('{1, 'h100, 0, 0, 'h000, 'h100, 1, 1, 'h200, 1});
        vecs.push_back('{0, 'h000, 0, 0, 'h000, 'h100, 1, 1, 'h200, 0});
        vecs.push_back('{1, 'h140, 1, 0, 'h300, 'h140, 0, 0, 'h000, 1});
        vecs.push_back('{0, 'h000, 0, 0, 'h000, 'h100, 0, 0, 'h000, 0});
        vecs.push_back('{0, 'h000, 0, 0, 'h000, 'h140, 1, 1, 'h300, 0});
        vecs.push_back('{1, 'h040, 1, 0, 'h060, 'h040, 0, 0, 'h000, 1});
        vecs.push_back('{1, 'h040, 0, 0, 'h000, 'h040, 1, 1, 'h060, 1});
        vecs.push_back('{1, 'h040, 0, 0, 'h000, 'h040, 1, 0, 'h060, 0});
        vecs.push_back('{1, 'h040, 1, 1, 'h080, 'h040, 1, 0, 'h060, 1});
        vecs.push_back('{0, 'h000, 0, 0, 'h000, 'h040, 1, 1, 'h080, 0});
        vecs.push_back('{1, 'h040, 0, 0, 'h000, 'h040, 1, 1, 'h080, 1});
        vecs.push_back('{0, 'h000, 0, 0, 'h000, 'h043, 1, 1, 'h080, 0});
        vecs.push_back('{1, 'h040, 1, 0, 'h090, 'h040, 1, 1, 'h080, 1});
        vecs.push_back('{1, 'h040, 1, 0, 'h090, 'h040, 1, 1, 'h090, 0});

        foreach (vecs[k]) begin
            upd_en_i = vecs[k].en; upd_pc_i = vecs[k].pc; upd_taken_i = vecs[k].tk;
            upd_jump_i = vecs[k].jp; upd_target_i = vecs[k].tgt;
            lookup_check($sformatf("vec%0d", k), vecs[k].lpc, vecs[k].e_hit, vecs[k].e_tk, vecs[k].e_tgt);
            @(posedge clk_i);
            #1;
            check($sformatf("vec%0d mispred", k), W'(mispred_o), W'(vecs[k].e_mis));
        end

        // Reset arriving in the middle of an update cycle discards the update and clears all entries.
        upd_en_i = 1; upd_pc_i = 'h200; upd_taken_i = 1; upd_jump_i = 0; upd_target_i = 'h400;
        #2 rst_ni = 1'b0;
        @(posedge clk_i);
        #1;
        upd_en_i = 0;
        check("rst mispred", W'(mispred_o), 0);
        lookup_check("rst 0x40", 'h040, 0, 0, 0);
        lookup_check("rst 0x140", 'h140, 0, 0, 0);
        lookup_check("rst 0x200", 'h200, 0, 0, 0);
`ifdef BTB_PERF_CNT_EN
        check("perf_lookup mid rst", perf_lookup_o, 0);
        check("perf_hit mid rst", perf_hit_o, 0);
        check("perf_mispred mid rst", perf_mispred_o, 0);
`endif
        rst_ni = 1'b1;
        model_reset();

        for (int c = 0; c < 400; c++) begin
            logic [W-1:0] upc, lpc;
            upc = W'(($urandom_range(0, 3) << 6) | ($urandom_range(0, D - 1) << 2) | $urandom_range(0, 3));
            lpc = ($urandom_range(0, 3) == 0) ? upc :
                  W'(($urandom_range(0, 3) << 6) | ($urandom_range(0, D - 1) << 2) | $urandom_range(0, 3));
            upd_en_i = ($urandom_range(0, 3) != 0);
            upd_pc_i = upc;
            upd_jump_i = ($urandom_range(0, 7) == 0);
            upd_taken_i = upd_jump_i | ($urandom_range(0, 1) == 1);
            upd_target_i = W'($urandom_range(0, 3) << 4);
            model_predict(lpc, eh, et, eg);
            lookup_check("rand", lpc, eh, et, eg);
            em = 0;
            if (upd_en_i) model_update(upc, upd_taken_i, upd_jump_i, upd_target_i, em);
            @(posedge clk_i);
            #1;
            check("rand mispred", W'(mispred_o), W'(em));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
